// File: rtl/text_vram_pkg.sv
// Shared definitions for the text VRAM writer: geometry defaults, word layout,
// control codes, power-up attribute/blank character and the writer FSM states.
package text_vram_pkg;

  localparam int unsigned TV_COLS = 80;
  localparam int unsigned TV_ROWS = 30;

  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned WORD_W = 16;

  // VRAM word fields: {bg, fg, char}
  localparam int unsigned CHAR_LSB = 0;
  localparam int unsigned CHAR_MSB = 7;
  localparam int unsigned FG_LSB   = 8;
  localparam int unsigned FG_MSB   = 11;
  localparam int unsigned BG_LSB   = 12;
  localparam int unsigned BG_MSB   = 15;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_TAB   = 8'h09;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_SPACE = 8'h20;

  localparam logic [7:0] TV_DEFAULT_ATTR = 8'h07;
  localparam logic [7:0] TV_BLANK_CHAR   = 8'h20;

  typedef enum logic [2:0] {
    ST_INIT_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_CLEAR_LINE,
    ST_CLEAR_SCREEN
  } console_state_e;

  function automatic logic [ADDR_W-1:0] vram_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [WORD_W-1:0] vram_word(input logic [7:0] attr,
                                                  input logic [7:0] ch);
    logic [WORD_W-1:0] w;
    w = '0;
    w[BG_MSB:BG_LSB]     = attr[7:4];
    w[FG_MSB:FG_LSB]     = attr[3:0];
    w[CHAR_MSB:CHAR_LSB] = ch;
    return w;
  endfunction

endpackage

// File: rtl/text_cursor_tracker.sv
// Cursor position registers and next-position rules for the console writer.
// Optional tab stops every 8 columns when TEXT_CONSOLE_TAB_EN is defined.
module text_cursor_tracker
  import text_vram_pkg::*;
#(
  parameter int unsigned COLS = TV_COLS,
  parameter int unsigned ROWS = TV_ROWS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_apply,
  input  logic             i_home,
  input  logic [7:0]       i_char,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_scroll
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_newline;
  logic             w_scroll;
`ifdef TEXT_CONSOLE_TAB_EN
  logic [7:0]       w_tab;
`endif

  // Next cursor position for i_char; a newline on the last row requests a scroll
  always_comb begin
    w_col     = r_col;
    w_row     = r_row;
    w_newline = 1'b0;
    w_scroll  = 1'b0;
`ifdef TEXT_CONSOLE_TAB_EN
    w_tab     = {1'b0, r_col[6:3], 3'b000} + 8'd8;
`endif
    if (i_char >= CC_SPACE) begin
      if (r_col == COL_W'(COLS - 1)) w_newline = 1'b1;
      else                           w_col = r_col + 7'd1;
    end else begin
      case (i_char)
        CC_LF: w_newline = 1'b1;
        CC_CR: w_col = '0;
        CC_BS: if (r_col != '0) w_col = r_col - 7'd1;
`ifdef TEXT_CONSOLE_TAB_EN
        CC_TAB: begin
          if (w_tab >= 8'(COLS)) w_newline = 1'b1;
          else                   w_col = w_tab[6:0];
        end
`endif
        default: ;
      endcase
    end
    if (w_newline) begin
      w_col = '0;
      if (r_row == ROW_W'(ROWS - 1)) w_scroll = 1'b1;
      else                           w_row = r_row + 6'd1;
    end
  end

  // Commit the cursor on byte accept; clears home it on completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_home) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_apply) begin
      r_col <= w_col;
      r_row <= w_row;
    end
  end

  assign o_col    = r_col;
  assign o_row    = r_row;
  assign o_scroll = w_scroll;

endmodule

// File: rtl/text_console_writer.sv
// Console writer for the text VRAM: accepts a byte stream, writes characters at
// the cursor, scrolls and clears the screen. Tab support: TEXT_CONSOLE_TAB_EN.
module text_console_writer
  import text_vram_pkg::*;
#(
  parameter int unsigned COLS         = TV_COLS,
  parameter int unsigned ROWS         = TV_ROWS,
  parameter logic [7:0]  DEFAULT_ATTR = TV_DEFAULT_ATTR,
  parameter logic [7:0]  BLANK_CHAR   = TV_BLANK_CHAR
) (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_char_valid,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        out_char_ready,
  output logic [12:0] out_vmem_address,
  output logic        out_vmem_write_en,
  output logic [15:0] out_vmem_write_data,
  output logic        out_vmem_read_en,
  input  logic [15:0] in_vmem_read_data,
  output logic [6:0]  out_cursor_col,
  output logic [5:0]  out_cursor_row,
  output logic        out_busy
);

  console_state_e r_state, w_state;
  logic [6:0]  r_scan_row, w_scan_row;
  logic [7:0]  r_scan_col, w_scan_col;
  logic        r_scroll_pend, w_scroll_pend;
  logic [7:0]  r_attr;
  logic        r_ready, r_busy, r_we, r_re, r_pass;
  logic        w_we, w_re, w_pass;
  logic [12:0] r_addr, w_addr;
  logic [15:0] r_wdata, w_wdata;
  logic        w_accept, w_home, w_scroll_go, w_last_col;
  logic [6:0]  w_cur_col;
  logic [5:0]  w_cur_row;
  logic        w_trk_scroll;

  assign w_accept = r_ready & in_char_valid;

  text_cursor_tracker #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .i_clk    (in_clock),
    .i_rst    (in_reset),
    .i_apply  (w_accept),
    .i_home   (w_home),
    .i_char   (in_char),
    .o_col    (w_cur_col),
    .o_row    (w_cur_row),
    .o_scroll (w_trk_scroll)
  );

  // Next state plus the VRAM strobes/address/data to present next cycle.
  // Clears run one cycle behind their scan counter (the reset cycle cannot write);
  // the scroll path presents the access matching the state it enters.
  always_comb begin
    w_state       = r_state;
    w_scan_row    = r_scan_row;
    w_scan_col    = r_scan_col;
    w_scroll_pend = r_scroll_pend;
    w_we          = 1'b0;
    w_re          = 1'b0;
    w_pass        = 1'b0;
    w_addr        = r_addr;
    w_wdata       = r_wdata;
    w_home        = 1'b0;
    w_scroll_go   = 1'b0;
    w_last_col    = (r_scan_col == 8'(COLS - 1));
    case (r_state)
      ST_INIT_CLEAR, ST_CLEAR_SCREEN: begin
        if (r_scan_row == 7'(ROWS)) begin
          w_state = ST_IDLE;
          w_home  = 1'b1;
        end else begin
          w_we    = 1'b1;
          w_addr  = vram_addr(6'(r_scan_row), 7'(r_scan_col));
          w_wdata = vram_word(r_attr, BLANK_CHAR);
          if (w_last_col) begin
            w_scan_col = '0;
            w_scan_row = r_scan_row + 7'd1;
          end else begin
            w_scan_col = r_scan_col + 8'd1;
          end
        end
      end
      ST_IDLE: begin
        if (in_char_valid) begin
          if (in_char >= CC_SPACE) begin
            w_state       = ST_WRITE;
            w_we          = 1'b1;
            w_addr        = vram_addr(w_cur_row, w_cur_col);
            w_wdata       = vram_word(in_attr, in_char);
            w_scroll_pend = w_trk_scroll;
          end else if (in_char == CC_FF) begin
            w_state    = ST_CLEAR_SCREEN;
            w_scan_row = '0;
            w_scan_col = '0;
          end else if (w_trk_scroll) begin
            w_scroll_go = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_scroll_pend = 1'b0;
        if (r_scroll_pend) w_scroll_go = 1'b1;
        else               w_state = ST_IDLE;
      end
      ST_SCROLL_RD: begin
        w_state = ST_SCROLL_WR;
        w_we    = 1'b1;
        w_pass  = 1'b1;
        w_addr  = vram_addr(6'(r_scan_row - 7'd1), 7'(r_scan_col));
      end
      ST_SCROLL_WR: begin
        if (w_last_col && (r_scan_row == 7'(ROWS - 1))) begin
          w_state    = ST_CLEAR_LINE;
          w_scan_col = '0;
          w_we       = 1'b1;
          w_addr     = vram_addr(6'(ROWS - 1), 7'd0);
          w_wdata    = vram_word(r_attr, BLANK_CHAR);
        end else begin
          w_state = ST_SCROLL_RD;
          w_re    = 1'b1;
          if (w_last_col) begin
            w_scan_col = '0;
            w_scan_row = r_scan_row + 7'd1;
          end else begin
            w_scan_col = r_scan_col + 8'd1;
          end
          w_addr = vram_addr(6'(w_scan_row), 7'(w_scan_col));
        end
      end
      ST_CLEAR_LINE: begin
        if (w_last_col) begin
          w_state = ST_IDLE;
        end else begin
          w_scan_col = r_scan_col + 8'd1;
          w_we       = 1'b1;
          w_addr     = vram_addr(6'(ROWS - 1), 7'(w_scan_col));
          w_wdata    = vram_word(r_attr, BLANK_CHAR);
        end
      end
      default: w_state = ST_INIT_CLEAR;
    endcase
    if (w_scroll_go) begin
      w_state    = ST_SCROLL_RD;
      w_re       = 1'b1;
      w_scan_row = 7'd1;
      w_scan_col = '0;
      w_addr     = vram_addr(6'd1, 7'd0);
    end
  end

  // State, scan counters and registered VRAM/handshake outputs
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state       <= ST_INIT_CLEAR;
      r_scan_row    <= '0;
      r_scan_col    <= '0;
      r_scroll_pend <= 1'b0;
      r_attr        <= DEFAULT_ATTR;
      r_ready       <= 1'b0;
      r_busy        <= 1'b1;
      r_we          <= 1'b0;
      r_re          <= 1'b0;
      r_pass        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      r_state       <= w_state;
      r_scan_row    <= w_scan_row;
      r_scan_col    <= w_scan_col;
      r_scroll_pend <= w_scroll_pend;
      if (w_accept) r_attr <= in_attr;
      r_ready       <= (w_state == ST_IDLE);
      r_busy        <= (w_state != ST_IDLE);
      r_we          <= w_we;
      r_re          <= w_re;
      r_pass        <= w_pass;
      r_addr        <= w_addr;
      r_wdata       <= w_wdata;
    end
  end

  // Scroll writes forward the word read one cycle earlier, keeping two cycles per cell
  assign out_vmem_write_data = r_pass ? in_vmem_read_data : r_wdata;
  assign out_char_ready      = r_ready;
  assign out_busy            = r_busy;
  assign out_vmem_write_en   = r_we;
  assign out_vmem_read_en    = r_re;
  assign out_vmem_address    = r_addr;
  assign out_cursor_col      = w_cur_col;
  assign out_cursor_row      = w_cur_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: screen/cursor model plus an
// expected-write queue, checked against every VRAM write.
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  ch = 8'h00;
  logic [7:0]  attr = 8'h00;
  logic        ready, we, re, busy;
  logic [12:0] addr;
  logic [15:0] wdata, rdata;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;

  text_console_writer dut (
    .in_clock            (clk),
    .in_reset            (rst),
    .in_char_valid       (valid),
    .in_char             (ch),
    .in_attr             (attr),
    .out_char_ready      (ready),
    .out_vmem_address    (addr),
    .out_vmem_write_en   (we),
    .out_vmem_write_data (wdata),
    .out_vmem_read_en    (re),
    .in_vmem_read_data   (rdata),
    .out_cursor_col      (cur_col),
    .out_cursor_row      (cur_row),
    .out_busy            (busy)
  );

  always #5 clk = ~clk;

  // VRAM: synchronous write, read data one cycle after read_en
  logic [15:0] mem [0:8191];
  logic [15:0] rd_q = 16'hDEAD;
  assign rdata = rd_q;
  initial for (int i = 0; i < 8192; i++) mem[i] = 16'hDEAD;
  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rd_q <= mem[addr];
  end

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string name, logic ok, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endfunction

  // Model: screen contents, cursor, expected write sequence {addr, data}
  logic [15:0] scr [0:ROWS-1][0:COLS-1];
  logic [28:0] expq [$];
  int m_row = 0, m_col = 0;

  task automatic push(input int r, input int c, input logic [15:0] d);
    scr[r][c] = d;
    expq.push_back({6'(r), 7'(c), d});
  endtask

  task automatic m_newline(input logic [7:0] at);
    m_col = 0;
    if (m_row == ROWS - 1) begin
      for (int r = 1; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) push(r - 1, c, scr[r][c]);
      for (int c = 0; c < COLS; c++) push(ROWS - 1, c, {at, 8'h20});
    end else begin
      m_row++;
    end
  endtask

  task automatic m_clear(input logic [7:0] at);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push(r, c, {at, 8'h20});
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_apply(input logic [7:0] b, input logic [7:0] at);
    if (b >= 8'h20) begin
      push(m_row, m_col, {at, b});
      if (m_col == COLS - 1) m_newline(at);
      else m_col++;
    end else if (b == 8'h0A) m_newline(at);
    else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) m_clear(at);
`ifdef TEXT_CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      int t;
      t = (m_col / 8) * 8 + 8;
      if (t >= COLS) m_newline(at);
      else m_col = t;
    end
`endif
  endtask

  // Per-cycle compare of DUT activity against the model
  int wr_count = 0;
  logic [12:0] last_addr = '0;
  logic [15:0] last_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_is_not_busy", ready != busy, {31'd0, ready}, {31'd0, ~busy});
      check("rd_wr_exclusive", !(we && re), {30'd0, we, re}, 32'd0);
      if (we) begin
        logic [28:0] e;
        wr_count++;
        last_addr = addr;
        last_data = wdata;
        check("write_in_visible_area", (addr[6:0] < COLS) && (addr[12:7] < ROWS), {19'd0, addr}, 32'd0);
        if (expq.size() == 0) begin
          check("unexpected_write", 1'b0, {19'd0, addr}, 32'd0);
        end else begin
          e = expq.pop_front();
          check("write_addr", addr == e[28:16], {19'd0, addr}, {19'd0, e[28:16]});
          check("write_data", wdata == e[15:0], {16'd0, wdata}, {16'd0, e[15:0]});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] at);
    int n = 0;
    while (!ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", ready, 32'(n), 32'd20000);
    model_apply(b, at);
    valid = 1'b1;
    ch = b;
    attr = at;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    while (!ready && busy_cycles < 20000) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("idle_timeout", ready, 32'(busy_cycles), 32'd0);
    check("queue_drained", expq.size() == 0, 32'(expq.size()), 32'd0);
  endtask

  task automatic check_first_write(input string name);
    int n = 0;
    while (!we && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_addr"}, we && addr == 13'h0000, {19'd0, addr}, 32'h0);
    check({name, "_data"}, we && wdata == 16'h0720, {16'd0, wdata}, 32'h0720);
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_model_row"}, m_row == r, 32'(m_row), 32'(r));
    check({name, "_model_col"}, m_col == c, 32'(m_col), 32'(c));
    check({name, "_row"}, cur_row == 6'(r), {26'd0, cur_row}, 32'(r));
    check({name, "_col"}, cur_col == 7'(c), {25'd0, cur_col}, 32'(c));
  endtask

  task automatic check_screen(input string name);
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mem[{6'(r), 7'(c)}] != scr[r][c]) bad++;
    check(name, bad == 0, 32'(bad), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout actual=%0d required=0", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int bad;
    // Reset state
    m_clear(8'h07);
    repeat (3) @(negedge clk);
    check("rst_ready", ready == 1'b0, {31'd0, ready}, 32'd0);
    check("rst_busy", busy == 1'b1, {31'd0, busy}, 32'd1);
    check("rst_we_re", !we && !re, {30'd0, we, re}, 32'd0);
    check("rst_addr_data", addr == '0 && wdata == '0, {3'd0, addr, wdata}, 32'd0);
    check("rst_cursor", cur_row == '0 && cur_col == '0, {19'd0, cur_row, cur_col}, 32'd0);
    rst = 1'b0;

    // Power-up clear
    wr_count = 0;
    check_first_write("init_first");
    wait_idle(bc);
    check("init_writes", wr_count == 2400, 32'(wr_count), 32'd2400);
    check_cursor("init_cursor", 0, 0);
    check_screen("init_screen");

    // Single printable byte
    wr_count = 0;
    send(8'h41, 8'h1E);
    wait_idle(bc);
    check("A_ready_low_cycles", bc == 1, 32'(bc), 32'd1);
    check("A_writes", wr_count == 1, 32'(wr_count), 32'd1);
    check("A_addr", last_addr == 13'h0000, {19'd0, last_addr}, 32'h0);
    check("A_data", last_data == 16'h1E41, {16'd0, last_data}, 32'h1E41);
    check_cursor("A_cursor", 0, 1);

    // 81 bytes from (0,0): wrap onto row 1
    send(8'h0D, 8'h07);
    wait_idle(bc);
    for (int i = 0; i < 81; i++) begin
      send(8'h61 + 8'(i % 26), 8'h07);
      wait_idle(bc);
    end
    check("wrap_addr", last_addr == 13'h0080, {19'd0, last_addr}, 32'h80);
    check_cursor("wrap_cursor", 1, 1);

    // Tab
    send(8'h09, 8'h07);
    wait_idle(bc);
`ifdef TEXT_CONSOLE_TAB_EN
    check_cursor("tab_cursor", 1, 8);
`else
    check_cursor("tab_cursor", 1, 1);
`endif

    // BS at column 0
    send(8'h0D, 8'h07);
    wait_idle(bc);
    wr_count = 0;
    send(8'h08, 8'h07);
    wait_idle(bc);
    check("bs_no_write", wr_count == 0, 32'(wr_count), 32'd0);
    check_cursor("bs_cursor", 1, 0);

    // CR at (3,40)
    send(8'h0A, 8'h07);
    wait_idle(bc);
    send(8'h0A, 8'h07);
    wait_idle(bc);
    for (int i = 0; i < 40; i++) begin
      send(8'h30 + 8'(i % 10), 8'h07);
      wait_idle(bc);
    end
    check_cursor("pre_cr_cursor", 3, 40);
    send(8'h0D, 8'h07);
    wait_idle(bc);
    check_cursor("cr_cursor", 3, 0);

    // LF scroll from (29,5)
    for (int i = 0; i < 26; i++) begin
      send(8'h0A, 8'h07);
      wait_idle(bc);
    end
    for (int i = 0; i < 5; i++) begin
      send(8'h4B + 8'(i), 8'h07);
      wait_idle(bc);
    end
    check_cursor("pre_scroll_cursor", 29, 5);
    wr_count = 0;
    send(8'h0A, 8'h2F);
    wait_idle(bc);
    check("scroll_busy_cycles", bc == 4720, 32'(bc), 32'd4720);
    check("scroll_writes", wr_count == 2400, 32'(wr_count), 32'd2400);
    check_cursor("scroll_cursor", 29, 0);
    bad = 0;
    for (int c = 0; c < COLS; c++) if (mem[{6'd29, 7'(c)}] != 16'h2F20) bad++;
    check("scroll_last_row_blank", bad == 0, 32'(bad), 32'd0);
    check_screen("scroll_screen");

    // Form feed
    wr_count = 0;
    send(8'h0C, 8'h40);
    wait_idle(bc);
    check("ff_writes", wr_count == 2400, 32'(wr_count), 32'd2400);
    check("ff_last_data", last_data == 16'h4020, {16'd0, last_data}, 32'h4020);
    check_cursor("ff_cursor", 0, 0);
    check_screen("ff_screen");

    // Printable at (29,79): write then scroll
    for (int i = 0; i < 29; i++) begin
      send(8'h0A, 8'h07);
      wait_idle(bc);
    end
    for (int i = 0; i < 79; i++) begin
      send(8'h21 + 8'(i % 90), 8'h5A);
      wait_idle(bc);
    end
    check_cursor("pre_wrapscroll_cursor", 29, 79);
    send(8'h7E, 8'h3C);
    wait_idle(bc);
    check("wrapscroll_busy_cycles", bc == 4721, 32'(bc), 32'd4721);
    check_cursor("wrapscroll_cursor", 29, 0);
    check("wrapscroll_moved_char", mem[{6'd28, 7'd79}] == 16'h3C7E, {16'd0, mem[{6'd28, 7'd79}]}, 32'h3C7E);
    check_screen("wrapscroll_screen");

    // Reset 100 cycles into a scroll
    send(8'h0A, 8'h11);
    repeat (99) @(negedge clk);
    check("mid_scroll_busy", busy == 1'b1, {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", we == 1'b0, {31'd0, we}, 32'd0);
    check("abort_re", re == 1'b0, {31'd0, re}, 32'd0);
    expq.delete();
    m_clear(8'h07);
    repeat (2) @(negedge clk);
    check("abort_cursor", cur_row == '0 && cur_col == '0, {19'd0, cur_row, cur_col}, 32'd0);
    rst = 1'b0;
    wr_count = 0;
    check_first_write("restart_first");
    wait_idle(bc);
    check("restart_writes", wr_count == 2400, 32'(wr_count), 32'd2400);
    check_cursor("restart_cursor", 0, 0);
    check_screen("restart_screen");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
